// File: rtl/stack_cpu_controller.sv
// Multi-cycle Moore control FSM for the 8-bit stack-machine datapath.
// Sequences one instruction at a time, gates on run at instruction boundaries, counts retirements.
module stack_cpu_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             pcEn,
  output logic             insEn,
  output logic             dataEn,
  output logic             Aen,
  output logic             Ben,
  output logic             resultEn,
  output logic             jumpSel,
  output logic             dataAdrSel,
  output logic             memDataSel,
  output logic             pcPlus,
  output logic             WE,
  output logic             RE,
  output logic             push,
  output logic             pop,
  output logic             tos,
  output logic [1:0]       aluSignal,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_IF    = 4'd1,
    S_ID    = 4'd2,
    S_POPA  = 4'd3,
    S_POPB  = 4'd4,
    S_EXEC  = 4'd5,
    S_WB    = 4'd6,
    S_MEMRD = 4'd7,
    S_PUSHM = 4'd8,
    S_MEMWR = 4'd9,
    S_JUMP  = 4'd10,
    S_TOSA  = 4'd11,
    S_JZCHK = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pcEn       = 1'b0;
    insEn      = 1'b0;
    dataEn     = 1'b0;
    Aen        = 1'b0;
    Ben        = 1'b0;
    resultEn   = 1'b0;
    jumpSel    = 1'b0;
    dataAdrSel = 1'b0;
    memDataSel = 1'b0;
    pcPlus     = 1'b0;
    WE         = 1'b0;
    RE         = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    tos        = 1'b0;
    aluSignal  = 2'b00;
    instr_done = 1'b0;

    case (state_q)
      S_INIT: begin
        if (run) state_d = S_IF;
      end
      S_IF: begin
        RE      = 1'b1;
        insEn   = 1'b1;
        pcPlus  = 1'b1;
        pcEn    = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        case (opcode)
          3'b100:  state_d = S_MEMRD;
          3'b110:  state_d = S_JUMP;
          3'b111:  state_d = S_TOSA;
          default: state_d = S_POPA;
        endcase
      end
      S_POPA: begin
        pop = 1'b1;
        Aen = 1'b1;
        if (opcode == 3'b101)      state_d = S_MEMWR;
        else if (opcode == 3'b011) state_d = S_EXEC;
        else                       state_d = S_POPB;
      end
      S_POPB: begin
        pop     = 1'b1;
        Ben     = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        aluSignal = opcode[1:0];
        resultEn  = 1'b1;
        state_d   = S_WB;
      end
      S_WB: begin
        push       = 1'b1;
        instr_done = 1'b1;
        state_d    = run ? S_IF : S_INIT;
      end
      S_MEMRD: begin
        dataAdrSel = 1'b1;
        RE         = 1'b1;
        dataEn     = 1'b1;
        state_d    = S_PUSHM;
      end
      S_PUSHM: begin
        memDataSel = 1'b1;
        push       = 1'b1;
        instr_done = 1'b1;
        state_d    = run ? S_IF : S_INIT;
      end
      S_MEMWR: begin
        dataAdrSel = 1'b1;
        WE         = 1'b1;
        instr_done = 1'b1;
        state_d    = run ? S_IF : S_INIT;
      end
      S_JUMP: begin
        jumpSel    = 1'b1;
        pcEn       = 1'b1;
        instr_done = 1'b1;
        state_d    = run ? S_IF : S_INIT;
      end
      S_TOSA: begin
        tos     = 1'b1;
        Aen     = 1'b1;
        state_d = S_JZCHK;
      end
      S_JZCHK: begin
        // The only Mealy-style strobes: the branch is taken on the live zero flag.
        jumpSel    = zero;
        pcEn       = zero;
        instr_done = 1'b1;
        state_d    = run ? S_IF : S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, instr_done};
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

  a_we_re_excl: assert property (@(posedge clk) disable iff (!rst_n) !(WE && RE));
  a_push_pop_excl: assert property (@(posedge clk) disable iff (!rst_n) !(push && pop));
  a_pcen_states: assert property (@(posedge clk) disable iff (!rst_n)
    pcEn |-> (state_q == S_IF || state_q == S_JUMP || state_q == S_JZCHK));

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Directed bench for stack_cpu_controller: per-cycle expected control vectors are queued
// per instruction and popped against the DUT each cycle.
module tb_stack_cpu_controller;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n, run, zero;
  logic [2:0] opcode;
  logic pcEn, insEn, dataEn, Aen, Ben, resultEn, jumpSel, dataAdrSel, memDataSel, pcPlus;
  logic WE, RE, push, pop, tos, instr_done;
  logic [1:0] aluSignal;
  logic [3:0] state;
  logic [CNT_W-1:0] instr_count;

  stack_cpu_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .pcEn(pcEn), .insEn(insEn), .dataEn(dataEn), .Aen(Aen), .Ben(Ben), .resultEn(resultEn),
    .jumpSel(jumpSel), .dataAdrSel(dataAdrSel), .memDataSel(memDataSel), .pcPlus(pcPlus),
    .WE(WE), .RE(RE), .push(push), .pop(pop), .tos(tos), .aluSignal(aluSignal),
    .state(state), .instr_done(instr_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {state, pcEn, insEn, dataEn, Aen, Ben, resultEn, jumpSel, dataAdrSel, memDataSel,
  //  pcPlus, WE, RE, push, pop, tos, aluSignal, instr_done}
  logic [21:0] obs_vec;
  assign obs_vec = {state, pcEn, insEn, dataEn, Aen, Ben, resultEn, jumpSel, dataAdrSel,
                    memDataSel, pcPlus, WE, RE, push, pop, tos, aluSignal, instr_done};

  localparam logic [17:0] M_PCEN = 18'h1 << 17;
  localparam logic [17:0] M_INS  = 18'h1 << 16;
  localparam logic [17:0] M_DEN  = 18'h1 << 15;
  localparam logic [17:0] M_AEN  = 18'h1 << 14;
  localparam logic [17:0] M_BEN  = 18'h1 << 13;
  localparam logic [17:0] M_RES  = 18'h1 << 12;
  localparam logic [17:0] M_JSEL = 18'h1 << 11;
  localparam logic [17:0] M_DADR = 18'h1 << 10;
  localparam logic [17:0] M_MDS  = 18'h1 << 9;
  localparam logic [17:0] M_PCP  = 18'h1 << 8;
  localparam logic [17:0] M_WE   = 18'h1 << 7;
  localparam logic [17:0] M_RE   = 18'h1 << 6;
  localparam logic [17:0] M_PUSH = 18'h1 << 5;
  localparam logic [17:0] M_POP  = 18'h1 << 4;
  localparam logic [17:0] M_TOS  = 18'h1 << 3;
  localparam logic [17:0] M_DONE = 18'h1;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [21:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] ev(input logic [3:0] st, input logic [17:0] m);
    return {st, m};
  endfunction

  function automatic logic [17:0] alu(input logic [1:0] a);
    return {15'd0, a, 1'b0};
  endfunction

  // Queue the expected per-cycle vectors of one instruction, IF through its last state.
  task automatic instr(input logic [2:0] op, input logic z);
    opcode = op;
    zero   = z;
    exp_q.push_back(ev(4'd1, M_RE | M_INS | M_PCP | M_PCEN));
    exp_q.push_back(ev(4'd2, 18'd0));
    case (op)
      3'b000, 3'b001, 3'b010: begin
        exp_q.push_back(ev(4'd3, M_POP | M_AEN));
        exp_q.push_back(ev(4'd4, M_POP | M_BEN));
        exp_q.push_back(ev(4'd5, M_RES | alu(op[1:0])));
        exp_q.push_back(ev(4'd6, M_PUSH | M_DONE));
      end
      3'b011: begin
        exp_q.push_back(ev(4'd3, M_POP | M_AEN));
        exp_q.push_back(ev(4'd5, M_RES | alu(2'b11)));
        exp_q.push_back(ev(4'd6, M_PUSH | M_DONE));
      end
      3'b100: begin
        exp_q.push_back(ev(4'd7, M_DADR | M_RE | M_DEN));
        exp_q.push_back(ev(4'd8, M_MDS | M_PUSH | M_DONE));
      end
      3'b101: begin
        exp_q.push_back(ev(4'd3, M_POP | M_AEN));
        exp_q.push_back(ev(4'd9, M_DADR | M_WE | M_DONE));
      end
      3'b110: exp_q.push_back(ev(4'd10, M_JSEL | M_PCEN | M_DONE));
      default: begin
        exp_q.push_back(ev(4'd11, M_TOS | M_AEN));
        exp_q.push_back(ev(4'd12, (z ? (M_JSEL | M_PCEN) : 18'd0) | M_DONE));
      end
    endcase
  endtask

  // Drain the queue one cycle per entry; optionally drop run or pulse reset mid-stream.
  task automatic run_seq(input string tag, input bit retire, input int drop_at, input int abort_at);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      logic [21:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s.cyc%0d", tag, i), 32'(obs_vec), 32'(e));
      if (i == drop_at) run = 1'b0;
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk($sformatf("%s.rst_outs", tag), 32'(obs_vec), 32'd0);
        chk($sformatf("%s.rst_cnt", tag), 32'(instr_count), 32'd0);
        exp_q.delete();
        exp_cnt = 0;
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    if (retire) begin
      exp_cnt = (exp_cnt + 1) % 16;
      chk($sformatf("%s.count", tag), 32'(instr_count), 32'(exp_cnt));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("we_re_excl", 32'(WE && RE), 32'd0);
      chk("push_pop_excl", 32'(push && pop), 32'd0);
      chk("pcen_state", 32'(pcEn && !(state == 4'd1 || state == 4'd10 || state == 4'd12)), 32'd0);
    end
  end

  initial begin
    rst_n  = 1'b0;
    run    = 1'b0;
    opcode = 3'b000;
    zero   = 1'b0;
    #12;
    chk("reset_outs", 32'(obs_vec), 32'd0);
    chk("reset_cnt", 32'(instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    exp_q.push_back(ev(4'd0, 18'd0));
    exp_q.push_back(ev(4'd0, 18'd0));
    run_seq("idle", 1'b0, -1, -1);

    run = 1'b1;
    exp_q.push_back(ev(4'd0, 18'd0));
    instr(3'b100, 1'b0); run_seq("push", 1'b1, -1, -1);
    instr(3'b001, 1'b0); run_seq("sub",  1'b1, -1, -1);
    instr(3'b011, 1'b0); run_seq("not",  1'b1, -1, -1);
    instr(3'b000, 1'b0); run_seq("add",  1'b1, -1, -1);
    instr(3'b010, 1'b0); run_seq("and",  1'b1, -1, -1);
    instr(3'b101, 1'b0); run_seq("pop",  1'b1, -1, -1);
    instr(3'b110, 1'b0); run_seq("jmp",  1'b1, -1, -1);
    instr(3'b111, 1'b1); run_seq("jz_taken", 1'b1, -1, -1);
    instr(3'b111, 1'b0); run_seq("jz_not",   1'b1, -1, -1);

    // run drops during POPB: ADD must still finish through WB, then park in INIT.
    instr(3'b000, 1'b0); run_seq("add_halt", 1'b1, 3, -1);
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(4'd0, 18'd0));
    run_seq("halted", 1'b0, -1, -1);
    run = 1'b1;
    exp_q.push_back(ev(4'd0, 18'd0));
    instr(3'b110, 1'b0); run_seq("resume_jmp", 1'b1, -1, -1);

    // Reset asserted mid-EXEC of an ADD.
    instr(3'b000, 1'b0); run_seq("add_abort", 1'b0, -1, 4);
    exp_q.push_back(ev(4'd0, 18'd0));
    exp_q.push_back(ev(4'd0, 18'd0));
    run_seq("post_rst", 1'b0, -1, -1);
    chk("post_rst_cnt", 32'(instr_count), 32'd0);

    run = 1'b1;
    exp_q.push_back(ev(4'd0, 18'd0));
    for (int i = 0; i < 17; i++) begin
      instr(3'b110, 1'b0);
      run_seq($sformatf("wrap_jmp%0d", i), 1'b1, -1, -1);
    end
    chk("wrap_cnt", 32'(instr_count), 32'd1);
    @(negedge clk);
    chk("final_state", 32'(state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
